// File: rtl/dp_seq_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module   : dp_seq_datapath_if
//  Purpose  : Instruction/status bundle between the controller and the
//             sequenced datapath.
//  Ports    : master - controller side (drives instruction fields, start,
//                      mdata, pc; observes busy/done/flags/dp_out/address)
//             slave  - datapath side (mirror of master)
//  Revision : 1.0  initial release
// ============================================================================
interface dp_seq_datapath_if #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int AW   = 9,
    parameter int PCW  = 9
);
    localparam int RW = $clog2(NREG);

    logic          start;
    logic [2:0]    op;
    logic [1:0]    shift;
    logic [RW-1:0] rd;
    logic [RW-1:0] rn;
    logic [RW-1:0] rm;
    logic          asel;
    logic          bsel;
    logic          csel;
    logic [W-1:0]  imm_b;
    logic [W-1:0]  imm_w;
    logic [W-1:0]  mdata;
    logic [PCW-1:0] pc;
    logic [3:0]    wb_sel;
    logic          write_en;
    logic          load_status;
    logic          load_addr;
    logic          busy;
    logic          done;
    logic          N;
    logic          V;
    logic          Z;
    logic [W-1:0]  dp_out;
    logic [AW-1:0] data_address;

    modport master (
        output start, op, shift, rd, rn, rm, asel, bsel, csel,
               imm_b, imm_w, mdata, pc, wb_sel, write_en, load_status, load_addr,
        input  busy, done, N, V, Z, dp_out, data_address
    );

    modport slave (
        input  start, op, shift, rd, rn, rm, asel, bsel, csel,
               imm_b, imm_w, mdata, pc, wb_sel, write_en, load_status, load_addr,
        output busy, done, N, V, Z, dp_out, data_address
    );
endinterface
`default_nettype wire

// File: rtl/dp_seq_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : dp_seq_datapath
//  Purpose  : Register-file datapath with a built-in 4-state micro-sequencer
//             (IDLE -> LOAD -> EXEC -> WB). One start pulse runs a whole
//             instruction; done pulses the cycle after WB.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - dp_seq_datapath_if.slave (instruction in, status out)
//  Options  : DP_SAT_ADD_EN - ADD/SUB saturate to signed max/min on overflow
//  Revision : 1.0  initial release
// ============================================================================
module dp_seq_datapath #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int AW   = 9,
    parameter int PCW  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    dp_seq_datapath_if.slave  bus
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   done_q, done_d;

    // Instruction fields captured on the accepting edge
    logic [2:0]    op_q;
    logic [1:0]    shift_q;
    logic [RW-1:0] rd_q, rn_q, rm_q;
    logic          asel_q, bsel_q, csel_q;
    logic [W-1:0]  imm_b_q, imm_w_q;
    logic [3:0]    wb_sel_q;
    logic          write_en_q, load_status_q, load_addr_q;

    logic [W-1:0]  regs_q [NREG];
    logic [W-1:0]  a_q, b_q, c_q;
    logic          n_q, v_q, z_q;
    logic [AW-1:0] addr_q;

    logic          accept;
    logic [W-1:0]  ain, bshift, bin, sum, diff, alu_res, wb_val;
    logic          ovf;
    logic [PCW-1:0] pc_inc;
    logic [W-1:0]  pc_inc_ext;

    assign accept = (state_q == S_IDLE) && bus.start;

    // ---------------- sequencer ----------------
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_LOAD;
            S_LOAD: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- ALU ----------------
    always_comb begin
        ain = asel_q ? '0 : a_q;
        case (shift_q)
            2'b01:   bshift = {b_q[W-2:0], 1'b0};
            2'b10:   bshift = {1'b0, b_q[W-1:1]};
            2'b11:   bshift = {b_q[W-1], b_q[W-1:1]};
            default: bshift = b_q;
        endcase
        bin     = bsel_q ? imm_b_q : bshift;
        sum     = ain + bin;
        diff    = ain - bin;
        ovf     = 1'b0;
        alu_res = bin;
        case (op_q)
            3'b000: begin
                alu_res = sum;
                ovf     = (ain[W-1] == bin[W-1]) && (sum[W-1] != ain[W-1]);
            end
            3'b001: begin
                alu_res = diff;
                ovf     = (ain[W-1] != bin[W-1]) && (diff[W-1] != ain[W-1]);
            end
            3'b010:  alu_res = ain & bin;
            3'b011:  alu_res = ~bin;
            3'b100:  alu_res = ain | bin;
            3'b101:  alu_res = ain ^ bin;
            default: alu_res = bin;
        endcase
`ifdef DP_SAT_ADD_EN
        // On overflow the true result has the sign of A, so clamp toward it.
        if (ovf) begin
            alu_res = ain[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`else
`endif
    end

    // ---------------- writeback source ----------------
    // pc+1 wraps within PCW bits before being fitted to the word width.
    assign pc_inc = bus.pc + {{(PCW-1){1'b0}}, 1'b1};

    generate
        if (PCW >= W) begin : g_pc_trunc
            assign pc_inc_ext = pc_inc[W-1:0];
        end else begin : g_pc_zext
            assign pc_inc_ext = {{(W-PCW){1'b0}}, pc_inc};
        end
    endgenerate

    always_comb begin
        wb_val = c_q;
        if (wb_sel_q[3])      wb_val = pc_inc_ext;
        else if (wb_sel_q[2]) wb_val = imm_w_q;
        else if (wb_sel_q[1]) wb_val = bus.mdata;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            done_q        <= 1'b0;
            op_q          <= '0;
            shift_q       <= '0;
            rd_q          <= '0;
            rn_q          <= '0;
            rm_q          <= '0;
            asel_q        <= 1'b0;
            bsel_q        <= 1'b0;
            csel_q        <= 1'b0;
            imm_b_q       <= '0;
            imm_w_q       <= '0;
            wb_sel_q      <= '0;
            write_en_q    <= 1'b0;
            load_status_q <= 1'b0;
            load_addr_q   <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            n_q           <= 1'b0;
            v_q           <= 1'b0;
            z_q           <= 1'b0;
            addr_q        <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                op_q          <= bus.op;
                shift_q       <= bus.shift;
                rd_q          <= bus.rd;
                rn_q          <= bus.rn;
                rm_q          <= bus.rm;
                asel_q        <= bus.asel;
                bsel_q        <= bus.bsel;
                csel_q        <= bus.csel;
                imm_b_q       <= bus.imm_b;
                imm_w_q       <= bus.imm_w;
                wb_sel_q      <= bus.wb_sel;
                write_en_q    <= bus.write_en;
                load_status_q <= bus.load_status;
                load_addr_q   <= bus.load_addr;
            end
            if (state_q == S_LOAD) begin
                a_q <= regs_q[rn_q];
                b_q <= regs_q[rm_q];
            end
            if (state_q == S_EXEC) begin
                c_q <= csel_q ? b_q : alu_res;
                if (load_status_q) begin
                    n_q <= alu_res[W-1];
                    v_q <= ovf;
                    z_q <= (alu_res == '0);
                end
                if (load_addr_q) addr_q <= alu_res[AW-1:0];
            end
            if ((state_q == S_WB) && write_en_q && (wb_sel_q != 4'b0000)) begin
                regs_q[rd_q] <= wb_val;
            end
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
    assign bus.N            = n_q;
    assign bus.V            = v_q;
    assign bus.Z            = z_q;
    assign bus.dp_out       = c_q;
    assign bus.data_address = addr_q;

endmodule
`default_nettype wire
